oled_src_arbiter: RTL and testbench
===================================

// Module: oled_src_arbiter
// PURPOSE
//  Shares the single 96x64 OLED pixel stream between N_SRC task renderers (each maps
//  pixel_index -> 16-bit RGB565). Selects one owner from a request vector (slide switches),
//  switches owner only at frame boundaries with one blank guard frame, and issues per-source
//  start and animation-step pulses, replacing per-renderer slow-clock dividers.
// PARAMETERS
//  N_SRC        4        number of renderer sources (2..8)
//  NUM_PIXELS   6144     pixels per frame (96*64); pixel_index range 0..NUM_PIXELS-1
//  FRAME_DIV    2        frames per anim_tick pulse (1..255)
//  BLANK_COLOR  16'h0000 colour driven with no owner and during guard frame
//  BORDER_COLOR 16'h07E0 border colour (OLED_ARB_BORDER_EN only)
// PORTS
//  basys_clk    in   1         system clock
//  rst_n        in   1         async active-low reset
//  pixel_index  in   13        current pixel from OLED driver
//  req          in   N_SRC     source requests (switches), level-sensitive, async-ok
//  src_data     in   16*N_SRC  pixel colour per source, src i at [16*i+15:16*i]
//  oled_data    out  16        registered pixel to OLED driver
//  grant        out  N_SRC     one-hot current owner, all-0 when none
//  start        out  N_SRC     1-cycle pulse to new owner on first owned frame
//  anim_tick    out  N_SRC     1-cycle step-enable to owner every FRAME_DIV frames
// BEHAVIOUR
//  - Reset: oled_data=BLANK_COLOR, grant=0, start=0, anim_tick=0, FSM=IDLE, frame_cnt=0.
//  - req double-flopped (2-cycle sync); winner = lowest-index asserted bit; none -> no winner.
//  - frame_start: 1-cycle strobe when pixel_index==0 and previous-cycle pixel_index!=0.
//  - FSM states (all transitions only on frame_start):
//    IDLE:  winner exists -> GUARD (latch pending=winner); else stay.
//    GUARD: one full frame of BLANK_COLOR; at next frame_start: pending still winner ->
//           ACTIVE, grant=onehot(pending), start[pending]=1 same cycle; winner changed ->
//           re-latch, stay GUARD; no winner -> IDLE.
//    ACTIVE: winner==owner -> stay; winner differs or none -> grant=0, then GUARD/IDLE as above.
//  - Owner change never mid-frame; req toggles within a frame are ignored unless still
//    present at frame_start (synchronised value sampled that cycle).
//  - oled_data: 1-cycle latency; ACTIVE: src_data[owner] registered; else BLANK_COLOR.
//  - frame_cnt (8b): cleared on entering ACTIVE; +1 each frame_start in ACTIVE; when it
//    reaches FRAME_DIV-1 at a frame_start, anim_tick[owner]=1 and frame_cnt wraps to 0.
//    FRAME_DIV=1 -> tick every frame. start and anim_tick never in the same cycle for
//    the same frame_start (first tick FRAME_DIV frames after start).
//  - pixel_index >= NUM_PIXELS: oled_data=BLANK_COLOR, no state effect.
//  - Reset mid-frame: all outputs to reset values immediately (async), restart in IDLE.
// CONFIGURATION
//  OLED_ARB_BORDER_EN defined: in ACTIVE, pixels with x==0, x==95, y==0 or y==63
//    (x=pixel_index%96, y=pixel_index/96) show BORDER_COLOR instead of src_data; same latency.
//  Not defined: no border logic; owner data on every pixel.
// TESTING
//  1 Reset, req=0, 3 frames -> grant=0, oled_data=16'h0000 all pixels, no pulses.
//  2 req=4'b0100 mid-frame -> next frame_start enter GUARD (blank frame), following
//    frame_start grant=4'b0100, start[2] 1 cycle; oled_data=src_data[2] delayed 1 cycle.
//  3 Owner 2, FRAME_DIV=2, 6 frames -> anim_tick[2] pulses at frames 2,4,6 only.
//  4 req 4'b0100->4'b0110 mid-frame -> owner 2 held to frame end, grant=0, 1 guard frame,
//    then grant=4'b0010 with start[1].
//  5 req pulse 4'b1000 for 100 cycles wholly inside a frame -> no GUARD, grant stays 0.
//  6 rst_n low at pixel_index=3000 in ACTIVE -> grant=0, oled_data=0 same cycle; with
//    OLED_ARB_BORDER_EN, pixel_index 0,95,96,6143 show 16'h07E0, pixel 97 shows src data.

Source files
------------

// File: rtl/oled_src_arbiter_if.sv
// Pixel-stream bundle between the OLED driver, the renderers and the
// source arbiter.
interface oled_src_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [12:0]         pixel_index;
    logic [N_SRC-1:0]    req;
    logic [16*N_SRC-1:0] src_data;
    logic [15:0]         oled_data;
    logic [N_SRC-1:0]    grant;
    logic [N_SRC-1:0]    start;
    logic [N_SRC-1:0]    anim_tick;

    modport master (
        output pixel_index, req, src_data,
        input  oled_data, grant, start, anim_tick
    );

    modport slave (
        input  pixel_index, req, src_data,
        output oled_data, grant, start, anim_tick
    );
endinterface

// File: rtl/oled_src_arbiter.sv
// Frame-synchronous owner arbiter for the shared 96x64 OLED pixel stream.
// Define OLED_ARB_BORDER_EN to overlay a one-pixel border on the owned frame.
module oled_src_arbiter #(
    parameter int          N_SRC       = 4,
    parameter int          NUM_PIXELS  = 6144,
    parameter int          FRAME_DIV   = 2,
    parameter logic [15:0] BLANK_COLOR = 16'h0000
`ifdef OLED_ARB_BORDER_EN
    ,
    parameter logic [15:0] BORDER_COLOR = 16'h07E0
`endif
) (
    input  logic              basys_clk,
    input  logic              rst_n,
    oled_src_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ACTIVE
    } state_e;

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   req_s1_q, req_s2_q;
    logic [12:0]        pix_prev_q;
    logic [IW-1:0]      pend_q, pend_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [N_SRC-1:0]   start_q, start_d;
    logic [N_SRC-1:0]   tick_q, tick_d;
    logic [15:0]        oled_q, oled_d;

    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic               frame_start;
    logic               in_range;
    logic [15:0]        src_sel;

    // Scan high to low so the lowest asserted request wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_s2_q[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end

    assign frame_start = (bus.pixel_index == 13'd0) &&
                         (pix_prev_q != 13'd0);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        start_d = '0;
        tick_d  = '0;
        if (frame_start) begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_d = GUARD;
                        pend_d  = win_idx;
                    end
                end
                GUARD: begin
                    if (!win_vld) begin
                        state_d = IDLE;
                    end else if (win_idx == pend_q) begin
                        state_d         = ACTIVE;
                        owner_d         = pend_q;
                        cnt_d           = '0;
                        start_d[pend_q] = 1'b1;
                    end else begin
                        pend_d = win_idx;
                    end
                end
                ACTIVE: begin
                    if (win_vld && (win_idx == owner_q)) begin
                        if (cnt_q == 8'(FRAME_DIV - 1)) begin
                            cnt_d           = '0;
                            tick_d[owner_q] = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (win_vld) begin
                        state_d = GUARD;
                        pend_d  = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        grant_d = '0;
        if (state_d == ACTIVE) grant_d[owner_d] = 1'b1;
    end

    // Use the next owner so the first pixel of an owned frame is already live.
    assign in_range = int'(bus.pixel_index) < NUM_PIXELS;
    assign src_sel  = bus.src_data[16*int'(owner_d) +: 16];

`ifdef OLED_ARB_BORDER_EN
    logic [12:0] px_x, px_y;
    logic        on_border;

    assign px_x      = bus.pixel_index % 13'd96;
    assign px_y      = bus.pixel_index / 13'd96;
    assign on_border = (px_x == 13'd0) || (px_x == 13'd95) ||
                       (px_y == 13'd0) || (px_y == 13'd63);

    always_comb begin
        oled_d = BLANK_COLOR;
        if (in_range && (state_d == ACTIVE)) begin
            oled_d = on_border ? BORDER_COLOR : src_sel;
        end
    end
`else
    always_comb begin
        oled_d = BLANK_COLOR;
        if (in_range && (state_d == ACTIVE)) oled_d = src_sel;
    end
`endif

    always_ff @(posedge basys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_s1_q   <= '0;
            req_s2_q   <= '0;
            pix_prev_q <= '0;
            pend_q     <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            start_q    <= '0;
            tick_q     <= '0;
            oled_q     <= BLANK_COLOR;
        end else begin
            state_q    <= state_d;
            req_s1_q   <= bus.req;
            req_s2_q   <= req_s1_q;
            pix_prev_q <= bus.pixel_index;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            start_q    <= start_d;
            tick_q     <= tick_d;
            oled_q     <= oled_d;
        end
    end

    assign bus.oled_data = oled_q;
    assign bus.grant     = grant_q;
    assign bus.start     = start_q;
    assign bus.anim_tick = tick_q;

endmodule

// File: tb/tb_oled_src_arbiter.sv
// Randomised bench for oled_src_arbiter against a frame-level model
// of ownership, guard frames, start and animation ticks.
module tb_oled_src_arbiter;
    localparam int N  = 4;
    localparam int FD = 2;
    localparam int NP = 6144;

    logic basys_clk = 1'b0;
    logic rst_n;
    always #5 basys_clk = ~basys_clk;

    oled_src_arbiter_if #(.N_SRC(N)) bus ();

    oled_src_arbiter #(
        .N_SRC(N),
        .NUM_PIXELS(NP),
        .FRAME_DIV(FD)
    ) dut (
        .basys_clk(basys_clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt = 0;

    // Model: owner/pending as source numbers, -1 meaning none.
    int          m_owner, m_pend;
    bit          m_guard;
    int          m_frames;
    logic [N-1:0] m_r1, m_r2;
    logic [12:0] m_prev;
    logic [15:0] e_oled;
    logic [N-1:0] e_grant, e_start, e_tick;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowbit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit border(input int p);
`ifdef OLED_ARB_BORDER_EN
        return (p % 96 == 0) || (p % 96 == 95) ||
               (p / 96 == 0) || (p / 96 == 63);
`else
        return p < 0;
`endif
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_pend   = -1;
        m_guard  = 1'b0;
        m_frames = 0;
        m_r1     = '0;
        m_r2     = '0;
        m_prev   = '0;
        e_oled   = 16'h0000;
        e_grant  = '0;
        e_start  = '0;
        e_tick   = '0;
    endtask

    // Decision at a frame boundary: wanted source is the request seen
    // two clocks ago (after synchronisation).
    task automatic model_step(input logic [12:0] pix,
                              input logic [N-1:0] r);
        int w;
        w = lowbit(m_r2);
        e_start = '0;
        e_tick  = '0;
        if (pix == 0 && m_prev != 0) begin
            if (m_owner >= 0 && w == m_owner) begin
                m_frames++;
                if (m_frames == FD) begin
                    m_frames = 0;
                    e_tick[m_owner] = 1'b1;
                end
            end else if (m_guard && w >= 0 && w == m_pend) begin
                m_guard  = 1'b0;
                m_owner  = w;
                m_frames = 0;
                e_start[w] = 1'b1;
            end else begin
                m_owner = -1;
                m_guard = (w >= 0);
                m_pend  = w;
            end
        end
        m_r2   = m_r1;
        m_r1   = r;
        m_prev = pix;
        e_grant = '0;
        e_oled  = 16'h0000;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            if (int'(pix) < NP) begin
                e_oled = border(int'(pix)) ? 16'h07E0 :
                         bus.src_data[16*m_owner +: 16];
            end
        end
    endtask

    task automatic drive(input logic [12:0] pix, input logic [N-1:0] r);
        bus.pixel_index = pix;
        bus.req = r;
        for (int i = 0; i < N; i++) bus.src_data[16*i +: 16] = 16'($urandom);
        model_step(pix, r);
    endtask

    task automatic cyc(input logic [12:0] pix, input logic [N-1:0] r);
        @(negedge basys_clk);
        chk("oled", 32'(bus.oled_data), 32'(e_oled));
        chk("grant", 32'(bus.grant), 32'(e_grant));
        chk("start", 32'(bus.start), 32'(e_start));
        chk("tick", 32'(bus.anim_tick), 32'(e_tick));
        if (bus.anim_tick != 0) tick_cnt++;
        drive(pix, r);
    endtask

    task automatic frame2(input int len, input logic [N-1:0] ra,
                          input int split, input logic [N-1:0] rb);
        for (int p = 0; p < len; p++) cyc(13'(p), (p < split) ? ra : rb);
    endtask

    task automatic frame(input int len, input logic [N-1:0] r);
        frame2(len, r, len, r);
    endtask

    task automatic do_reset();
        @(negedge basys_clk);
        rst_n = 1'b0;
        #1;
        chk("rst_oled", 32'(bus.oled_data), 32'h0);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_start", 32'(bus.start), 32'h0);
        chk("rst_tick", 32'(bus.anim_tick), 32'h0);
        repeat (2) @(negedge basys_clk);
        rst_n = 1'b1;
        model_reset();
        drive(13'd0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pixel_index = '0;
        bus.req = '0;
        bus.src_data = '0;
        model_reset();
        do_reset();

        // Idle: one full frame plus short ones, nothing granted.
        frame(NP, 4'b0000);
        frame(64, 4'b0000);
        frame(64, 4'b0000);
        chk("t1_grant", 32'(bus.grant), 32'h0);

        // Request source 2 mid-frame: guard frame, then ownership.
        frame2(50, 4'b0000, 20, 4'b0100);
        frame(50, 4'b0100);
        frame(50, 4'b0100);
        chk("t2_grant", 32'(bus.grant), 32'h4);

        // Six frames of ownership give three ticks with FRAME_DIV=2.
        tick_cnt = 0;
        for (int f = 0; f < 6; f++) frame(40, 4'b0100);
        chk("t3_ticks", 32'(tick_cnt), 32'd3);

        // Source 1 joins mid-frame and wins after one guard frame.
        frame2(50, 4'b0100, 25, 4'b0110);
        frame(50, 4'b0110);
        frame(50, 4'b0110);
        chk("t4_grant", 32'(bus.grant), 32'h2);

        // Release, then a short request pulse inside one frame.
        frame(40, 4'b0000);
        frame(40, 4'b0000);
        for (int p = 0; p < 300; p++)
            cyc(13'(p), (p >= 50 && p < 150) ? 4'b1000 : 4'b0000);
        frame(40, 4'b0000);
        frame(40, 4'b0000);
        chk("t5_grant", 32'(bus.grant), 32'h0);

        // Reset in the middle of an owned frame.
        frame(40, 4'b0100);
        frame(40, 4'b0100);
        frame(40, 4'b0100);
        cyc(13'd1, 4'b0100);
        cyc(13'd3000, 4'b0100);
        cyc(13'd3001, 4'b0100);
        do_reset();

        // Edge pixels and out-of-range indices while owned.
        frame(40, 4'b0100);
        frame(40, 4'b0100);
        frame(40, 4'b0100);
        cyc(13'd95, 4'b0100);
        cyc(13'd96, 4'b0100);
        cyc(13'd97, 4'b0100);
        cyc(13'd6143, 4'b0100);
        cyc(13'd6144, 4'b0100);
        cyc(13'd8191, 4'b0100);
        cyc(13'd500, 4'b0100);

        // Random traffic: short frames, request changes, stray indices.
        begin
            logic [N-1:0] r;
            int len;
            r = 4'b0001;
            for (int f = 0; f < 150; f++) begin
                len = $urandom_range(48, 8);
                if ($urandom_range(49, 0) == 0) do_reset();
                for (int p = 0; p < len; p++) begin
                    if ($urandom_range(15, 0) == 0) begin
                        r = ($urandom_range(2, 0) == 0) ? 4'b0000 :
                            4'($urandom);
                    end
                    if ($urandom_range(15, 0) == 0)
                        cyc(13'($urandom_range(8191, NP)), r);
                    else
                        cyc(13'(p), r);
                end
            end
        end
        cyc(13'd1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
